// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: datapath widths, ALU op codes and
// operand-select encodings.
package id_ex_stage_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int REGADDR_DEF = 5;

  // ALU op codes; bit 3 is don't-care for SLL, PASSB, XOR, OR and AND
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_PASSB = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd1 - 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Priority operand forward: x0 reads zero, then MEM result, then WB result,
// then the value held in the ID/EX entry.
module id_ex_stage_fwd_mux #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input  logic [REGADDR-1:0] rs,
  input  logic [XLEN-1:0]    held,
  input  logic               mem_regwr,
  input  logic [REGADDR-1:0] mem_rd,
  input  logic [XLEN-1:0]    mem_result,
  input  logic               wb_regwr,
  input  logic [REGADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_result,
  output logic [XLEN-1:0]    data,
  output logic               wb_hit
);

  logic rs_zero;
  logic mem_hit;

  assign rs_zero = (rs == '0);
  assign mem_hit = mem_regwr & (mem_rd == rs) & ~rs_zero;
  assign wb_hit  = wb_regwr & (wb_rd == rs) & ~rs_zero;

  always_comb begin
    data = held;
    if (rs_zero)      data = '0;
    else if (mem_hit) data = mem_result;
    else if (wb_hit)  data = wb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds the decoded entry, forwards operands from
// MEM/WB, selects ALU inputs, and stalls one cycle on a load-use hazard.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int REGADDR = REGADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [REGADDR-1:0] id_rs1,
  input  logic [REGADDR-1:0] id_rs2,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [1:0]         id_srca,
  input  logic [1:0]         id_srcb,
  input  logic [3:0]         id_aluctr,
  input  logic [REGADDR-1:0] id_rd,
  input  logic               id_regwr,
  input  logic               id_memrd,
  input  logic               id_memwr,
  input  logic [REGADDR-1:0] mem_rd,
  input  logic               mem_regwr,
  input  logic [XLEN-1:0]    mem_result,
  input  logic [REGADDR-1:0] wb_rd,
  input  logic               wb_regwr,
  input  logic [XLEN-1:0]    wb_result,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_dataa,
  output logic [XLEN-1:0]    ex_datab,
  output logic [3:0]         ex_aluctr,
  output logic [XLEN-1:0]    ex_storedata,
  output logic [XLEN-1:0]    ex_pc,
  output logic [REGADDR-1:0] ex_rd,
  output logic               ex_regwr,
  output logic               ex_memrd,
  output logic               ex_memwr
);

  logic [REGADDR-1:0] rs1_q, rs2_q;
  logic [XLEN-1:0]    rs1_data_q, rs2_data_q, imm_q;
  logic [1:0]         srca_q, srcb_q;
  logic [XLEN-1:0]    rs1_fwd, rs2_fwd;
  logic               rs1_wb_hit, rs2_wb_hit;
  logic               advance, hazard;

  assign advance  = ~ex_valid | ex_ready;
  assign hazard   = ex_valid & ex_memrd & ex_regwr & (ex_rd != '0)
                  & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign id_ready = advance & ~hazard & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      srca_q     <= '0;
      srcb_q     <= '0;
      ex_aluctr  <= '0;
      ex_rd      <= '0;
      ex_regwr   <= 1'b0;
      ex_memrd   <= 1'b0;
      ex_memwr   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      // a hazard still loads the fields but marks the slot as a bubble
      ex_valid   <= id_valid & id_ready;
      ex_pc      <= id_pc;
      rs1_q      <= id_rs1;
      rs2_q      <= id_rs2;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
      srca_q     <= id_srca;
      srcb_q     <= id_srcb;
      ex_aluctr  <= id_aluctr;
      ex_rd      <= id_rd;
      ex_regwr   <= id_regwr;
      ex_memrd   <= id_memrd;
      ex_memwr   <= id_memwr;
    end else begin
      // capture WB values while stalled so they outlive the writer
      if (rs1_wb_hit) rs1_data_q <= wb_result;
      if (rs2_wb_hit) rs2_data_q <= wb_result;
    end
  end

  id_ex_stage_fwd_mux #(.XLEN(XLEN), .REGADDR(REGADDR)) u_fwd_rs1 (
    .rs(rs1_q), .held(rs1_data_q),
    .mem_regwr(mem_regwr), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwr(wb_regwr), .wb_rd(wb_rd), .wb_result(wb_result),
    .data(rs1_fwd), .wb_hit(rs1_wb_hit)
  );

  id_ex_stage_fwd_mux #(.XLEN(XLEN), .REGADDR(REGADDR)) u_fwd_rs2 (
    .rs(rs2_q), .held(rs2_data_q),
    .mem_regwr(mem_regwr), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwr(wb_regwr), .wb_rd(wb_rd), .wb_result(wb_result),
    .data(rs2_fwd), .wb_hit(rs2_wb_hit)
  );

  always_comb begin
    ex_dataa = '0;
    case (srca_q)
      SRCA_RS1: ex_dataa = rs1_fwd;
      SRCA_PC:  ex_dataa = ex_pc;
      default:  ex_dataa = '0;
    endcase
  end

  always_comb begin
    ex_datab = '0;
    case (srcb_q)
      SRCB_RS2:  ex_datab = rs2_fwd;
      SRCB_IMM:  ex_datab = imm_q;
      SRCB_FOUR: ex_datab = XLEN'(4);
      default:   ex_datab = '0;
    endcase
  end

  assign ex_storedata = rs2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a cycle-level reference model and
// hand-computed checkpoints.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush, id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [1:0]  id_srca, id_srcb;
  logic [3:0]  id_aluctr, ex_aluctr;
  logic        id_regwr, id_memrd, id_memwr, mem_regwr, wb_regwr, ex_ready;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_regwr, ex_memrd, ex_memwr;
  logic [31:0] ex_dataa, ex_datab, ex_storedata, ex_pc;
  logic [4:0]  ex_rd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_srca(id_srca), .id_srcb(id_srcb),
    .id_aluctr(id_aluctr), .id_rd(id_rd), .id_regwr(id_regwr), .id_memrd(id_memrd),
    .id_memwr(id_memwr), .mem_rd(mem_rd), .mem_regwr(mem_regwr), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwr(wb_regwr), .wb_result(wb_result), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_dataa(ex_dataa), .ex_datab(ex_datab), .ex_aluctr(ex_aluctr),
    .ex_storedata(ex_storedata), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_regwr(ex_regwr),
    .ex_memrd(ex_memrd), .ex_memwr(ex_memwr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction sitting in EX, as seen by the pipeline.
  logic        m_valid;
  logic [31:0] m_pc, m_d1, m_d2, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [1:0]  m_srca, m_srcb;
  logic [3:0]  m_alu;
  logic        m_regwr, m_memrd, m_memwr;

  function automatic logic load_use();
    return m_valid && m_memrd && m_regwr && m_rd != 0 && (m_rd == id_rs1 || m_rd == id_rs2);
  endfunction

  function automatic logic exp_ready();
    return (!m_valid || ex_ready) && !load_use() && !flush;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] held);
    if (r == 0) return 32'h0;
    if (mem_regwr && mem_rd == r) return mem_result;
    if (wb_regwr && wb_rd == r) return wb_result;
    return held;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {m_valid, m_pc, m_d1, m_d2, m_imm, m_rs1, m_rs2, m_rd} = '0;
      {m_srca, m_srcb, m_alu, m_regwr, m_memrd, m_memwr} = '0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (!m_valid || ex_ready) begin
      m_valid = id_valid && exp_ready();
      m_pc = id_pc; m_rs1 = id_rs1; m_rs2 = id_rs2; m_d1 = id_rs1_data; m_d2 = id_rs2_data;
      m_imm = id_imm; m_srca = id_srca; m_srcb = id_srcb; m_alu = id_aluctr;
      m_rd = id_rd; m_regwr = id_regwr; m_memrd = id_memrd; m_memwr = id_memwr;
    end else begin
      if (m_rs1 != 0 && wb_regwr && wb_rd == m_rs1) m_d1 = wb_result;
      if (m_rs2 != 0 && wb_regwr && wb_rd == m_rs2) m_d2 = wb_result;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ea, eb;
    ea = (m_srca == 2'd0) ? operand(m_rs1, m_d1) : (m_srca == 2'd1) ? m_pc : 32'h0;
    case (m_srcb)
      2'd0:    eb = operand(m_rs2, m_d2);
      2'd1:    eb = m_imm;
      2'd2:    eb = 32'd4;
      default: eb = 32'h0;
    endcase
    chk("m_valid", {31'b0, ex_valid}, {31'b0, m_valid});
    chk("m_ready", {31'b0, id_ready}, {31'b0, exp_ready()});
    chk("m_dataa", ex_dataa, ea);
    chk("m_datab", ex_datab, eb);
    chk("m_store", ex_storedata, operand(m_rs2, m_d2));
    chk("m_pc", ex_pc, m_pc);
    chk("m_ctl", {19'b0, ex_aluctr, ex_rd, ex_regwr, ex_memrd, ex_memwr},
                 {19'b0, m_alu, m_rd, m_regwr, m_memrd, m_memwr});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [4:0] rd,
                       input logic memrd);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1;
    id_rs2_data = d2; id_imm = imm; id_srca = sa; id_srcb = sb; id_rd = rd;
    id_regwr = 1'b1; id_memrd = memrd; id_memwr = 1'b0; id_aluctr = 4'b1000;
  endtask

  initial begin
    flush = 0; id_valid = 1; id_pc = 32'h40; id_rs1 = 1; id_rs2 = 2;
    id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_imm = 0; id_srca = 0; id_srcb = 0;
    id_aluctr = 4'h7; id_rd = 3; id_regwr = 1; id_memrd = 0; id_memwr = 0;
    mem_rd = 0; mem_regwr = 0; mem_result = 0; wb_rd = 0; wb_regwr = 0; wb_result = 0;
    ex_ready = 1;

    // 1: reset holds the slot empty even with id_valid high
    step(); step();
    @(negedge clk);
    chk("rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_dataa", ex_dataa, 32'h0);
    chk("rst_aluctr", {28'b0, ex_aluctr}, 32'h0);
    step(); rst = 0; id_valid = 0;
    @(negedge clk);
    chk("rst_ready", {31'b0, id_ready}, 32'h1);

    // 2: rs1=x3 forwarded from MEM, then from WB
    step(); offer(32'h100, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 5'd4, 1'b0);
    step(); id_valid = 0; ex_ready = 0; mem_regwr = 1; mem_rd = 3; mem_result = 32'h10;
    @(negedge clk);
    chk("fwd_mem", ex_dataa, 32'h10);
    step(); mem_regwr = 0; wb_regwr = 1; wb_rd = 3; wb_result = 32'h22;
    @(negedge clk);
    chk("fwd_wb", ex_dataa, 32'h22);

    // 3: MEM beats WB; x0 never forwards
    step(); ex_ready = 1; wb_regwr = 0;
    offer(32'h104, 5'd5, 5'd0, 32'h99, 32'h0, 32'h0, 2'd0, 2'd2, 5'd6, 1'b0);
    step(); mem_regwr = 1; mem_rd = 5; mem_result = 32'hA; wb_regwr = 1; wb_rd = 5; wb_result = 32'hB;
    offer(32'h108, 5'd0, 5'd0, 32'h55, 32'h0, 32'h0, 2'd0, 2'd1, 5'd6, 1'b0);
    @(negedge clk);
    chk("mem_over_wb", ex_dataa, 32'hA);
    chk("srcb_four", ex_datab, 32'h4);
    step(); mem_rd = 0; mem_result = 32'h77; wb_regwr = 0;
    offer(32'h10C, 5'd1, 5'd0, 32'h200, 32'h0, 32'h8, 2'd0, 2'd1, 5'd7, 1'b1);
    @(negedge clk);
    chk("rs1_zero", ex_dataa, 32'h0);

    // 4: load to x7 now latched; consumer on rs2 takes one bubble
    step(); mem_regwr = 0;
    offer(32'h110, 5'd2, 5'd7, 32'h3, 32'h0, 32'h0, 2'd0, 2'd0, 5'd8, 1'b0);
    @(negedge clk);
    chk("hazard_ready", {31'b0, id_ready}, 32'h0);
    step();
    @(negedge clk);
    chk("bubble_valid", {31'b0, ex_valid}, 32'h0);
    chk("bubble_ready", {31'b0, id_ready}, 32'h1);
    step(); id_valid = 0; wb_regwr = 1; wb_rd = 7; wb_result = 32'hDEAD;
    @(negedge clk);
    chk("load_valid", {31'b0, ex_valid}, 32'h1);
    chk("load_fwd_wb", ex_datab, 32'hDEAD);

    // 5: three stall cycles while the WB writer of rs1 retires
    step(); wb_rd = 9; wb_result = 32'h900;
    offer(32'h2A0, 5'd9, 5'd0, 32'h1, 32'h0, 32'h0, 2'd0, 2'd0, 5'd10, 1'b0);
    step(); ex_ready = 0;
    offer(32'h300, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd1, 2'd3, 5'd11, 1'b0);
    @(negedge clk);
    chk("stall_ready", {31'b0, id_ready}, 32'h0);
    chk("stall_a0", ex_dataa, 32'h900);
    for (int i = 1; i < 3; i++) begin
      step(); wb_regwr = 0; wb_rd = 0; wb_result = 32'h0;
      @(negedge clk);
      chk("stall_a", ex_dataa, 32'h900);
      chk("stall_pc", ex_pc, 32'h2A0);
    end
    step(); ex_ready = 1;
    @(negedge clk);
    chk("release_ready", {31'b0, id_ready}, 32'h1);

    // 6: flush drops the held entry and refuses the ID entry
    step(); ex_ready = 0; flush = 1;
    offer(32'h400, 5'd1, 5'd1, 32'h1, 32'h1, 32'h0, 2'd0, 2'd0, 5'd12, 1'b0);
    @(negedge clk);
    chk("flush_ready", {31'b0, id_ready}, 32'h0);
    chk("flush_pre_pc", ex_pc, 32'h300);
    step(); flush = 0; id_valid = 0;
    @(negedge clk);
    chk("flush_valid", {31'b0, ex_valid}, 32'h0);
    chk("flush_pc", ex_pc, 32'h300);

    // reset while stalled drops the entry
    step(); ex_ready = 1;
    offer(32'h500, 5'd1, 5'd2, 32'h5, 32'h6, 32'h0, 2'd0, 2'd0, 5'd13, 1'b0);
    step(); ex_ready = 0; id_valid = 0;
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, ex_valid}, 32'h1);
    #2 rst = 1;
    #1 chk("midrst_valid", {31'b0, ex_valid}, 32'h0);
    chk("midrst_pc", ex_pc, 32'h0);
    step(); rst = 0; ex_ready = 1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
